// File: rtl/adc_input_capture.sv
// Capture controller: collects dsize samples (ADC or internal ramp) into a small
// FIFO and emits them as one AXI4-Stream packet with tlast on the final sample.
module adc_input_capture #(
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic [31:0]   dsize,
  input  logic          cr_test,
  input  logic          cr_start,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          busy,
  output logic          done,
  output logic          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   size_q, push_cnt_reg;
  logic          test_q;
  logic [DW-1:0] ramp_reg;
  logic          done_reg, overflow_reg;

  logic [DW:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic          start_ok, sample_ev, fifo_full, fifo_empty;
  logic          push, pop, push_last, head_last;
  logic [DW-1:0] sample;

  assign start_ok   = (state_reg == IDLE) && cr_start && (dsize != '0);
  assign sample_ev  = (state_reg == CAPTURE) && adc_valid;
  // Full is judged on registered occupancy, so a same-cycle pop never frees a slot.
  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign push       = sample_ev && !fifo_full;
  assign push_last  = (push_cnt_reg == size_q - 32'd1);
  assign sample     = test_q ? ramp_reg : adc_data;
  assign head_last  = mem[rd_ptr_reg][DW];
  assign pop        = m_axis_tvalid && m_axis_tready;

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : mem[rd_ptr_reg][DW-1:0];
  assign m_axis_tlast  = !fifo_empty && head_last;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign overflow      = overflow_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = CAPTURE;
      CAPTURE: if (push && push_last) state_next = DRAIN;
      DRAIN:   if (pop && head_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg    <= IDLE;
      size_q       <= '0;
      test_q       <= 1'b0;
      push_cnt_reg <= '0;
      ramp_reg     <= '0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        size_q       <= dsize;
        test_q       <= cr_test;
        push_cnt_reg <= '0;
        ramp_reg     <= '0;
        done_reg     <= 1'b0;
        overflow_reg <= 1'b0;
      end else begin
        if (sample_ev) ramp_reg <= ramp_reg + DW'(1);
        if (push) push_cnt_reg <= push_cnt_reg + 32'd1;
        if (sample_ev && fifo_full) overflow_reg <= 1'b1;
        if ((state_reg == DRAIN) && pop && head_last) done_reg <= 1'b1;
      end
    end
  end

  // Buffer contents need no reset: the occupancy counter alone marks them stale.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr_reg] <= {push_last, sample};
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_input_capture.sv
// Bench for adc_input_capture: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized packets.
module tb_adc_input_capture;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b1;
  logic [31:0]   dsize = '0;
  logic          cr_test = 1'b0;
  logic          cr_start = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, busy, done, overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 ACLK = ~ACLK;

  adc_input_capture #(.DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .dsize(dsize), .cr_test(cr_test),
    .cr_start(cr_start), .adc_data(adc_data), .adc_valid(adc_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: 0 = idle, 1 = capturing, 2 = draining; FIFO is a plain queue.
  int            m_state = 0;
  logic [31:0]   m_size, m_pushed;
  logic          m_test, m_done, m_ovf, m_full, m_pop;
  logic [DW-1:0] m_ramp, m_val;
  logic [DW:0]   m_head;
  logic [DW:0]   m_q[$];
  logic [DW-1:0] log_data[$];
  logic          log_last[$];
  int            log_cyc[$];

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_state = 0; m_size = '0; m_pushed = '0; m_test = 1'b0;
      m_done = 1'b0; m_ovf = 1'b0; m_ramp = '0;
      m_q.delete();
    end else begin
      cyc++;
      m_full = (m_q.size() == DEPTH);
      m_pop  = (m_q.size() != 0) && m_axis_tready;
      m_head = '0;
      if (m_pop) begin
        m_head = m_q.pop_front();
        log_data.push_back(m_head[DW-1:0]);
        log_last.push_back(m_head[DW]);
        log_cyc.push_back(cyc);
      end
      if (m_state == 0) begin
        if (cr_start && dsize != 0) begin
          m_state = 1; m_size = dsize; m_test = cr_test; m_pushed = '0;
          m_ramp = '0; m_done = 1'b0; m_ovf = 1'b0;
        end
      end else if (m_state == 1) begin
        if (adc_valid) begin
          m_val  = m_test ? m_ramp : adc_data;
          m_ramp = m_ramp + 1'b1;
          if (m_full) m_ovf = 1'b1;
          else begin
            m_q.push_back({(m_pushed == m_size - 1), m_val});
            if (m_pushed == m_size - 1) m_state = 2;
            m_pushed = m_pushed + 1;
          end
        end
      end else if (m_pop && m_head[DW]) begin
        m_state = 0;
        m_done  = 1'b1;
      end
    end
  end

  always @(negedge ACLK) begin
    chk("tvalid", m_axis_tvalid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("tdata", m_axis_tdata, m_q[0][DW-1:0]);
      chk("tlast", m_axis_tlast, m_q[0][DW]);
    end
    chk("busy", busy, m_state != 0);
    chk("done", done, m_done);
    chk("overflow", overflow, m_ovf);
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic start(input logic [31:0] n, input logic t);
    dsize = n; cr_test = t; cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
  endtask

  task automatic clear_log();
    log_data.delete(); log_last.delete(); log_cyc.delete();
  endtask

  task automatic wait_idle(input int limit, input bit rnd);
    int k = 0;
    while ((m_state != 0 || m_q.size() != 0) && k < limit) begin
      if (rnd) begin
        adc_valid = 1'($urandom); m_axis_tready = 1'($urandom); adc_data = DW'($urandom);
      end
      tick();
      k++;
    end
    chk("drain_within_bound", k < limit, 1'b1);
  endtask

  logic [DW-1:0] t4_vals [3];

  initial begin
    t4_vals[0] = 16'hA5A5; t4_vals[1] = 16'h1234; t4_vals[2] = 16'hFFFF;
    #1 ARESETN = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", m_axis_tvalid, 0); chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);   chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);            chk("rst_overflow", overflow, 0);
    ARESETN = 1'b1;
    tick();

    // 1: ramp, dsize 4, continuous valid and ready
    clear_log();
    adc_valid = 1'b1; m_axis_tready = 1'b1;
    start(4, 1'b1);
    wait_idle(100, 1'b0);
    chk("t1_len", log_data.size(), 4);
    for (int i = 0; i < 4 && i < log_data.size(); i++) begin
      chk("t1_data", log_data[i], i);
      chk("t1_last", log_last[i], i == 3);
      if (i > 0) chk("t1_back_to_back", log_cyc[i] - log_cyc[i-1], 1);
    end
    $display("t1 ramp dsize=4 beats=%0d done=%0b busy=%0b ovf=%0b", log_data.size(), done, busy, overflow);
    chk("t1_done", done, 1); chk("t1_busy", busy, 0); chk("t1_ovf", overflow, 0);

    // 2: zero-size start is ignored, done retained
    start(0, 1'b1);
    repeat (3) tick();
    chk("t2_busy", busy, 0); chk("t2_tvalid", m_axis_tvalid, 0); chk("t2_done", done, 1);
    $display("t2 dsize=0 start busy=%0b done=%0b", busy, done);

    // 3: overflow with stalled sink
    clear_log();
    m_axis_tready = 1'b0; adc_valid = 1'b1;
    start(20, 1'b1);
    repeat (25) tick();
    chk("t3_occupancy", m_q.size(), 16);
    chk("t3_ovf", overflow, 1); chk("t3_tvalid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    wait_idle(200, 1'b0);
    chk("t3_len", log_data.size(), 20);
    for (int i = 0; i < 20 && i < log_data.size(); i++) begin
      if (i < 16) chk("t3_data", log_data[i], i);
      chk("t3_last", log_last[i], i == 19);
    end
    if (log_data.size() == 20) begin
      chk("t3_gap", log_data[16] > 16, 1);
      for (int i = 17; i < 20; i++) chk("t3_tail", log_data[i], log_data[i-1] + 1'b1);
    end
    $display("t3 overflow beats=%0d ovf=%0b", log_data.size(), overflow);

    // 4: ADC source, gaps in valid, toggling ready
    clear_log();
    adc_valid = 1'b0;
    start(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(1, 3)) begin
        adc_valid = 1'b0; adc_data = DW'($urandom); m_axis_tready = 1'($urandom);
        tick();
      end
      adc_valid = 1'b1; adc_data = t4_vals[i]; m_axis_tready = 1'($urandom);
      tick();
    end
    wait_idle(300, 1'b1);
    chk("t4_len", log_data.size(), 3);
    for (int i = 0; i < 3 && i < log_data.size(); i++) begin
      chk("t4_data", log_data[i], t4_vals[i]);
      chk("t4_last", log_last[i], i == 2);
    end
    $display("t4 adc source beats=%0d", log_data.size());

    // 5: restart during capture ignored
    clear_log();
    adc_valid = 1'b1; m_axis_tready = 1'b1;
    start(5, 1'b1);
    tick();
    dsize = 9; cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
    wait_idle(100, 1'b0);
    chk("t5_len", log_data.size(), 5);
    $display("t5 restart ignored beats=%0d", log_data.size());

    // 6: asynchronous reset mid-capture
    clear_log();
    adc_valid = 1'b1; m_axis_tready = 1'b0;
    start(8, 1'b1);
    tick(); tick();
    chk("t6_pushed", m_q.size(), 2);
    #2 ARESETN = 1'b0;
    #1;
    chk("t6_tvalid", m_axis_tvalid, 0); chk("t6_tlast", m_axis_tlast, 0);
    chk("t6_tdata", m_axis_tdata, 0);   chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);            chk("t6_ovf", overflow, 0);
    tick(); tick();
    ARESETN = 1'b1;
    tick();
    clear_log();
    m_axis_tready = 1'b1;
    start(2, 1'b1);
    wait_idle(100, 1'b0);
    chk("t6_len", log_data.size(), 2);
    for (int i = 0; i < 2 && i < log_data.size(); i++) begin
      chk("t6_data", log_data[i], i);
      chk("t6_last", log_last[i], i == 1);
    end
    $display("t6 reset mid-capture then dsize=2 beats=%0d", log_data.size());

    // randomized packets
    for (int p = 0; p < 12; p++) begin
      int n, bias, k;
      n = $urandom_range(1, 40);
      bias = $urandom_range(0, 3);
      k = 0;
      clear_log();
      adc_valid = 1'($urandom); adc_data = DW'($urandom);
      start(n, 1'($urandom));
      while (m_state != 0 && k < 3000) begin
        adc_valid = ($urandom_range(0, 3) != 0);
        adc_data = DW'($urandom);
        m_axis_tready = ($urandom_range(0, 3) >= bias);
        cr_start = ($urandom_range(0, 15) == 0);
        dsize = $urandom_range(0, 50);
        tick();
        k++;
      end
      cr_start = 1'b0;
      chk("rnd_bound", k < 3000, 1'b1);
      chk("rnd_len", log_data.size(), n);
      if (log_data.size() > 0) chk("rnd_final_last", log_last[log_data.size()-1], 1'b1);
      $display("rnd pkt %0d dsize=%0d beats=%0d ovf=%0b", p, n, log_data.size(), overflow);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
